// File: rtl/spi_cfg_master.sv
// SPI mode-0 initiator for the 16-bit {rw, addr[6:0], data[7:0]} register-write link.
// Define SPI_CFG_MASTER_READBACK_EN to capture the responder's sdo byte into rsp_data.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned CS_HOLD    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       sclk,
  output logic       sdi,
  output logic       cs,
  input  logic       sdo
);

  localparam int unsigned FW    = 16;
  localparam int unsigned BW    = 5;
  localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_B = (CS_HOLD > GAP_CYCLES) ? CS_HOLD : GAP_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FW);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FW-1:0]   sreg, sreg_nxt;
  logic            cs_nxt, sclk_nxt, sdi_nxt, busy_nxt, ready_nxt, rsp_valid_nxt;
  logic [7:0]      rsp_data_nxt;

`ifdef SPI_CFG_MASTER_READBACK_EN
  logic [FW-1:0]   rd_sreg, rd_sreg_nxt;
`else
  logic            unused_sdo;
  assign unused_sdo = sdo;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CW'(1);
    bit_cnt_nxt   = bit_cnt;
    sreg_nxt      = sreg;
    cs_nxt        = cs;
    sclk_nxt      = sclk;
    sdi_nxt       = sdi;
    busy_nxt      = busy;
    ready_nxt     = req_ready;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
`ifdef SPI_CFG_MASTER_READBACK_EN
    rd_sreg_nxt   = rd_sreg;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_valid && req_ready) begin
          state_nxt   = SETUP;
          sreg_nxt    = {req_write, req_addr, req_data};
          bit_cnt_nxt = '0;
          cs_nxt      = 1'b0;
          sdi_nxt     = req_write;
          busy_nxt    = 1'b1;
          ready_nxt   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) begin
          state_nxt = SHIFT_LO;
          cnt_nxt   = '0;
        end
      end
      SHIFT_LO: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_nxt   = SHIFT_HI;
          cnt_nxt     = '0;
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = (bit_cnt == LAST_BIT) ? bit_cnt : bit_cnt + BW'(1);
`ifdef SPI_CFG_MASTER_READBACK_EN
          rd_sreg_nxt = (rd_sreg << 1) | FW'(sdo);
`endif
        end
      end
      SHIFT_HI: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_nxt  = '0;
          sclk_nxt = 1'b0;
          // sdi moves on the falling edge so it is centred on the next rise
          if (bit_cnt == LAST_BIT) begin
            state_nxt = HOLD;
            sdi_nxt   = 1'b0;
          end else begin
            state_nxt = SHIFT_LO;
            sdi_nxt   = sreg[FW-2];
            sreg_nxt  = sreg << 1;
          end
        end
      end
      HOLD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          state_nxt     = GAP;
          cnt_nxt       = '0;
          cs_nxt        = 1'b1;
          rsp_valid_nxt = 1'b1;
`ifdef SPI_CFG_MASTER_READBACK_EN
          rsp_data_nxt  = rd_sreg[7:0];
`endif
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        cs_nxt    = 1'b1;
        sclk_nxt  = 1'b0;
        sdi_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sreg      <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      sdi       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sreg      <= sreg_nxt;
      cs        <= cs_nxt;
      sclk      <= sclk_nxt;
      sdi       <= sdi_nxt;
      busy      <= busy_nxt;
      req_ready <= ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

`ifdef SPI_CFG_MASTER_READBACK_EN
  // Responder byte capture, sampled on every sclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sreg <= '0;
    else        rd_sreg <= rd_sreg_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: random frames against a frame-level model, default and CLK_DIV=6 builds.
module tb_spi_cfg_master;

  localparam int SETUP_C = 4;
  localparam int HOLD_C  = 4;
  localparam int GAP_C   = 8;
  localparam int DIV_A   = 4;
  localparam int DIV_B   = 6;
`ifdef SPI_CFG_MASTER_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       sdo = 1'b0;
  logic       sel = 1'b0;

  logic       ready_a, busy_a, rv_a, sclk_a, sdi_a, cs_a;
  logic [7:0] rd_a;
  logic       ready_b, busy_b, rv_b, sclk_b, sdi_b, cs_b;
  logic [7:0] rd_b;
  logic       valid_a, valid_b;

  assign valid_a = req_valid & ~sel;
  assign valid_b = req_valid & sel;

  spi_cfg_master dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_a), .rsp_valid(rv_a), .rsp_data(rd_a),
    .sclk(sclk_a), .sdi(sdi_a), .cs(cs_a), .sdo(sdo)
  );

  spi_cfg_master #(.CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .busy(busy_b), .rsp_valid(rv_b), .rsp_data(rd_b),
    .sclk(sclk_b), .sdi(sdi_b), .cs(cs_b), .sdo(sdo)
  );

  logic       m_ready, m_busy, m_rv, m_sclk, m_sdi, m_cs;
  logic [7:0] m_rd;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_rv    = sel ? rv_b    : rv_a;
  assign m_rd    = sel ? rd_b    : rd_a;
  assign m_sclk  = sel ? sclk_b  : sclk_a;
  assign m_sdi   = sel ? sdi_b   : sdi_a;
  assign m_cs    = sel ? cs_b    : cs_a;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder model: presents sdo_pat MSB first, next bit after each observed sclk rise.
  logic [15:0] sdo_pat = '0;
  int          sdo_r = 0;
  logic        sdo_prev = 1'b0;
  always @(negedge clk) begin
    if (m_cs !== 1'b0) sdo_r = 0;
    else if (m_sclk === 1'b1 && sdo_prev === 1'b0) sdo_r = sdo_r + 1;
    sdo_prev = m_sclk;
    sdo = (sdo_r < 16) ? sdo_pat[15 - sdo_r] : 1'b0;
  end

  task automatic launch(input logic [15:0] f);
    @(negedge clk);
    {req_write, req_addr, req_data} = f;
    req_valid = 1'b1;
  endtask

  // Observes one whole frame on the wire from cs fall until busy drops; no judging here.
  task automatic capture(input bit drop_valid, input logic [15:0] next_f,
                         output logic [15:0] bits, output int cs_low, output int rises,
                         output int rsp_cnt, output logic [7:0] rsp, output int min_margin,
                         output int min_half, output int max_half, output int gap_busy,
                         output int fall_time, output bit timeout);
    int budget, i, last_chg, last_rise, last_tr, ntr, h;
    logic prev_sclk, prev_sdi;
    bits = '0; cs_low = 0; rises = 0; rsp_cnt = 0; rsp = '0; min_margin = 1000;
    min_half = 1000; max_half = 0; gap_busy = 0; fall_time = 0; timeout = 1'b0; budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (m_cs !== 1'b0 && budget < 500);
    if (m_cs !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    fall_time = cyc;
    if (drop_valid) req_valid = 1'b0;
    else {req_write, req_addr, req_data} = next_f;
    i = 0; prev_sclk = m_sclk; prev_sdi = m_sdi; last_chg = 0; last_rise = -1000;
    last_tr = 0; ntr = 0;
    while (m_cs === 1'b0 && budget < 3000) begin
      cs_low++;
      if (i > 0 && m_sdi !== prev_sdi) begin
        if (i - last_rise < min_margin) min_margin = i - last_rise;
        last_chg = i;
      end
      if (m_sclk !== prev_sclk) begin
        if (ntr > 0) begin
          h = i - last_tr;
          if (h < min_half) min_half = h;
          if (h > max_half) max_half = h;
        end
        ntr++;
        last_tr = i;
        if (m_sclk === 1'b1) begin
          rises++;
          bits = {bits[14:0], m_sdi};
          if (i - last_chg < min_margin) min_margin = i - last_chg;
          last_rise = i;
        end
      end
      if (m_rv === 1'b1) begin rsp_cnt++; rsp = m_rd; end
      prev_sclk = m_sclk; prev_sdi = m_sdi; i++;
      @(negedge clk);
      budget++;
    end
    while (m_busy === 1'b1 && budget < 3000) begin
      if (m_rv === 1'b1) begin rsp_cnt++; rsp = m_rd; end
      if (m_cs === 1'b1) gap_busy++;
      @(negedge clk);
      budget++;
    end
    if (m_cs !== 1'b1 || m_busy !== 1'b0) timeout = 1'b1;
  endtask

  logic [15:0] bits;
  logic [7:0]  rsp;
  int cs_low, rises, rsp_cnt, min_margin, min_half, max_half, gap_busy, fall_t;
  bit timeout;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (m_cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", m_cs); end
    checks++; if (m_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", m_sclk); end
    checks++; if (m_sdi !== 1'b0) begin failures++; $display("FAIL reset_sdi got=%b exp=0", m_sdi); end
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", m_ready); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
    checks++; if (m_rv !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", m_rv); end
    checks++; if (m_rd !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", m_rd); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full frame check against the frame-level model for the currently selected instance.
  task automatic one_frame(input string name, input logic [15:0] f, input logic [15:0] pat, input int div);
    int exp_low;
    logic [7:0] exp_rsp;
    exp_low = SETUP_C + 32 * div + HOLD_C;
    exp_rsp = RB_EN ? pat[7:0] : 8'h00;
    sdo_pat = pat;
    launch(f);
    capture(1'b1, 16'h0, bits, cs_low, rises, rsp_cnt, rsp, min_margin, min_half, max_half,
            gap_busy, fall_t, timeout);
    checks++; if (timeout) begin failures++; $display("FAIL %s_timeout got=1 exp=0", name); end
    checks++; if (bits !== f) begin failures++; $display("FAIL %s_bits got=%h exp=%h", name, bits, f); end
    checks++; if (rises != 16) begin failures++; $display("FAIL %s_rises got=%0d exp=16", name, rises); end
    checks++; if (cs_low != exp_low) begin failures++; $display("FAIL %s_cs_low got=%0d exp=%0d", name, cs_low, exp_low); end
    checks++; if (rsp_cnt != 1) begin failures++; $display("FAIL %s_rsp_cnt got=%0d exp=1", name, rsp_cnt); end
    checks++; if (rsp !== exp_rsp) begin failures++; $display("FAIL %s_rsp_data got=%h exp=%h", name, rsp, exp_rsp); end
    checks++; if (min_half != div || max_half != div) begin
      failures++; $display("FAIL %s_half_period got=%0d..%0d exp=%0d", name, min_half, max_half, div);
    end
    checks++; if (min_margin < div) begin failures++; $display("FAIL %s_sdi_margin got=%0d exp>=%0d", name, min_margin, div); end
    checks++; if (gap_busy != GAP_C) begin failures++; $display("FAIL %s_gap got=%0d exp=%0d", name, gap_busy, GAP_C); end
  endtask

  task automatic test_write;
    one_frame("write_a5", 16'h83A5, 16'($urandom), DIV_A);
  endtask

  task automatic test_readback;
    one_frame("readback", 16'($urandom), 16'h005A, DIV_A);
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) one_frame("random", 16'($urandom), 16'($urandom), DIV_A);
  endtask

  task automatic test_back_to_back;
    int fall1;
    sdo_pat = 16'($urandom);
    launch(16'h8111);
    capture(1'b0, 16'h8222, bits, cs_low, rises, rsp_cnt, rsp, min_margin, min_half, max_half,
            gap_busy, fall1, timeout);
    checks++; if (timeout || bits !== 16'h8111) begin failures++; $display("FAIL b2b_first got=%h exp=8111", bits); end
    // Request still held: this IDLE cycle is where the second accept happens.
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", m_ready); end
    checks++; if (gap_busy != GAP_C) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap_busy, GAP_C); end
    capture(1'b1, 16'h0, bits, cs_low, rises, rsp_cnt, rsp, min_margin, min_half, max_half,
            gap_busy, fall_t, timeout);
    checks++; if (timeout || bits !== 16'h8222) begin failures++; $display("FAIL b2b_second got=%h exp=8222", bits); end
    checks++; if (fall_t - fall1 != 1 + SETUP_C + 32 * DIV_A + HOLD_C + GAP_C) begin
      failures++; $display("FAIL b2b_period got=%0d exp=%0d", fall_t - fall1, 1 + SETUP_C + 32 * DIV_A + HOLD_C + GAP_C);
    end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] f1, f2;
    logic ready_seen;
    int extra;
    f1 = 16'($urandom);
    f2 = ~f1;
    ready_seen = 1'b0;
    launch(f1);
    fork
      capture(1'b1, 16'h0, bits, cs_low, rises, rsp_cnt, rsp, min_margin, min_half, max_half,
              gap_busy, fall_t, timeout);
      begin
        repeat (40) @(negedge clk);
        {req_write, req_addr, req_data} = f2;
        req_valid = 1'b1;
        ready_seen = m_ready;
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    checks++; if (ready_seen !== 1'b0) begin failures++; $display("FAIL ignore_ready got=%b exp=0", ready_seen); end
    checks++; if (timeout || bits !== f1) begin failures++; $display("FAIL ignore_bits got=%h exp=%h", bits, f1); end
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (m_cs !== 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra_frame got=%0d exp=0", extra); end
  endtask

  task automatic test_clk_div6;
    sel = 1'b1;
    one_frame("div6", 16'($urandom), 16'h005A, DIV_B);
    one_frame("div6_rand", 16'($urandom), 16'($urandom), DIV_B);
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_midframe;
    launch(16'($urandom));
    @(negedge clk);
    req_valid = 1'b0;
    repeat (58) @(negedge clk);
    checks++; if (m_cs !== 1'b0) begin failures++; $display("FAIL midrst_in_frame got=%b exp=0", m_cs); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_cs !== 1'b1 || m_sclk !== 1'b0 || m_sdi !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=cs%b sclk%b sdi%b rdy%b busy%b exp=cs1 sclk0 sdi0 rdy1 busy0",
               m_cs, m_sclk, m_sdi, m_ready, m_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (m_cs !== 1'b1 || m_busy !== 1'b0) begin
      failures++; $display("FAIL midrst_no_resume got=cs%b busy%b exp=cs1 busy0", m_cs, m_busy);
    end
    one_frame("after_reset", 16'($urandom), 16'($urandom), DIV_A);
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_clk_div6();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
